// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and default widths
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_DIV_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - even/odd parity bit over a payload word
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_bit
);

  // Odd parity is the even-parity bit inverted.
  assign parity_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, data LSB first, optional parity, stop
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                  i_pulse_gen_clk,
  input  logic                  i_pulse_gen_rst,
  input  logic                  i_tx_data_valid,
  input  logic [DATA_WIDTH-1:0] i_tx_p_data,
  input  logic                  i_tx_par_en,
  input  logic                  i_tx_par_typ,
  input  logic [DIV_WIDTH-1:0]  i_tx_div,
  output logic                  o_tx_out,
  output logic                  o_tx_busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]       LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]       BIT_ONE  = BCW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  tx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  latch;
  logic                  bit_done;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  parity_bit;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data       (data_q),
    .par_typ    (par_typ_q),
    .parity_bit (parity_bit)
  );

  assign bit_done = (div_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    latch     = 1'b0;

    // Reload at each bit boundary, otherwise count down; never wraps.
    if (state_q != ST_IDLE) begin
      div_cnt_d = bit_done ? (div_q - DIV_ONE) : (div_cnt_q - DIV_ONE);
    end

    case (state_q)
      ST_IDLE: begin
        tx_out_d  = 1'b1;
        busy_d    = 1'b0;
        div_cnt_d = '0;
        if (i_tx_data_valid) begin
          latch     = 1'b1;
          state_d   = ST_START;
          div_cnt_d = (i_tx_div == '0) ? '0 : (i_tx_div - DIV_ONE);
          bit_cnt_d = '0;
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_out_d  = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d  = par_en_q ? ST_PARITY : ST_STOP;
            tx_out_d = par_en_q ? parity_bit : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            tx_out_d  = data_q[bit_cnt_d];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d  = ST_STOP;
          tx_out_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
          tx_out_d  = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
        tx_out_d  = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_pulse_gen_clk or posedge i_pulse_gen_rst) begin
    if (i_pulse_gen_rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      if (latch) begin
        data_q    <= i_tx_p_data;
        par_en_q  <= i_tx_par_en;
        par_typ_q <= i_tx_par_typ;
        div_q     <= (i_tx_div == '0) ? DIV_ONE : i_tx_div;
      end
    end
  end

  assign o_tx_out  = tx_out_q;
  assign o_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  pdata;
  logic        par_en;
  logic        par_typ;
  logic [15:0] div;
  logic        tx_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_framer #(
    .DATA_WIDTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .i_pulse_gen_clk (clk),
    .i_pulse_gen_rst (rst),
    .i_tx_data_valid (valid),
    .i_tx_p_data     (pdata),
    .i_tx_par_en     (par_en),
    .i_tx_par_typ    (par_typ),
    .i_tx_div        (div),
    .o_tx_out        (tx_out),
    .o_tx_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " line"}, {31'd0, tx_out}, 32'd1);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse(input logic [7:0] d, input logic pe, input logic pt, input logic [15:0] dv);
    pdata   = d;
    par_en  = pe;
    par_typ = pt;
    div     = dv;
    valid   = 1'b1;
    @(negedge clk);
    valid   = 1'b0;
  endtask

  // Walks a frame one cycle at a time; inject_at drives a stray valid with changed inputs.
  task automatic check_frame(input string name, input logic [7:0] d, input bit pe, input bit pbit,
                             input int dv, input int inject_at, input int stop_at);
    int   n;
    int   idx;
    logic e;
    n = (10 + (pe ? 1 : 0)) * dv;
    for (int c = 0; c < n && c < stop_at; c++) begin
      idx = c / dv;
      if (idx == 0)                e = 1'b0;
      else if (idx <= 8)           e = d[idx-1];
      else if (pe && idx == 9)     e = pbit;
      else                         e = 1'b1;
      chk($sformatf("%s line c%0d", name, c), {31'd0, tx_out}, {31'd0, e});
      chk($sformatf("%s busy c%0d", name, c), {31'd0, busy}, 32'd1);
      if (c == inject_at) begin
        valid   = 1'b1;
        pdata   = 8'hFF;
        par_en  = 1'b1;
        par_typ = 1'b1;
        div     = 16'd1;
      end else begin
        valid   = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    pdata   = 8'h00;
    par_en  = 1'b0;
    par_typ = 1'b0;
    div     = 16'd1;

    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk_idle("post reset");
    end

    pulse(8'hA5, 1'b0, 1'b0, 16'd4);
    check_frame("a5", 8'hA5, 1'b0, 1'b0, 4, -1, 1000);
    chk_idle("a5 end");
    @(negedge clk);

    pulse(8'h07, 1'b1, 1'b0, 16'd2);
    check_frame("p_even", 8'h07, 1'b1, 1'b1, 2, -1, 1000);
    chk_idle("p_even end");
    @(negedge clk);

    pulse(8'h07, 1'b1, 1'b1, 16'd2);
    check_frame("p_odd", 8'h07, 1'b1, 1'b0, 2, -1, 1000);
    chk_idle("p_odd end");
    @(negedge clk);

    pulse(8'h00, 1'b0, 1'b0, 16'd2);
    check_frame("ignore", 8'h00, 1'b0, 1'b0, 2, 5, 1000);
    repeat (6) begin
      chk_idle("ignore after");
      @(negedge clk);
    end

    pulse(8'h00, 1'b0, 1'b0, 16'd4);
    check_frame("rst_mid", 8'h00, 1'b0, 1'b0, 4, -1, 17);
    #2 rst = 1'b1;
    #1 chk_idle("rst_mid async");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk_idle("rst_mid after");
    end

    pulse(8'h55, 1'b0, 1'b0, 16'd0);
    check_frame("div0", 8'h55, 1'b0, 1'b0, 1, -1, 1000);
    chk_idle("b2b gap");
    pulse(8'h3C, 1'b1, 1'b1, 16'd3);
    check_frame("b2b", 8'h3C, 1'b1, 1'b1, 3, -1, 1000);
    chk_idle("b2b end");
    @(negedge clk);
    chk_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 Parameter DIV_WIDTH, default 16, width of the clocks-per-bit divisor.
REQ-003 i_pulse_gen_clk  input  1  system clock; all state updates on rising edge.
REQ-004 i_pulse_gen_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_tx_data_valid  input  1  single-cycle start request; driven by the upstream level-to-pulse generator.
REQ-006 i_tx_p_data  input  DATA_WIDTH  parallel payload; sampled only on accept.
REQ-007 i_tx_par_en  input  1  1 = append parity bit.
REQ-008 i_tx_par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 i_tx_div  input  DIV_WIDTH  clock cycles per serial bit.
REQ-010 o_tx_out  output  1  serial line, idle high.
REQ-011 o_tx_busy  output  1  high while a frame is in progress.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 Accept: in IDLE, i_tx_data_valid high at a rising edge SHALL latch i_tx_p_data, i_tx_par_en, i_tx_par_typ and i_tx_div, and move to START.
REQ-014 i_tx_data_valid SHALL be ignored in every state other than IDLE; no queuing.
REQ-015 Input changes after accept SHALL NOT affect the frame in flight.
REQ-016 Outputs SHALL be registered; o_tx_out = 0 and o_tx_busy = 1 from the cycle after accept.
REQ-017 Each bit SHALL hold for exactly latched div cycles; a latched div of 0 SHALL be treated as 1.
REQ-018 Bit counter: START 1 bit -> DATA, DATA_WIDTH bits LSB first -> PARITY if par_en else STOP -> PARITY 1 bit -> STOP.
REQ-019 Parity bit SHALL equal XOR of latched data when even, and its inverse when odd.
REQ-020 STOP SHALL drive 1 for div cycles, then return to IDLE; o_tx_busy SHALL fall on the same edge.
REQ-021 Frame length SHALL be (DATA_WIDTH+2+par_en)*div cycles, from the first low cycle to the cycle busy falls.
REQ-022 Back-to-back: a valid pulse sampled in the first IDLE cycle SHALL be accepted; the line SHALL stay high for exactly 1 cycle between frames.
REQ-023 The divisor counter SHALL count down from latched div-1 to 0 and reload on each bit boundary; it SHALL never wrap.

Reset
REQ-024 Reset assertion SHALL immediately force IDLE, o_tx_out = 1, o_tx_busy = 0, and clear counters and latched data, including mid-frame.
REQ-025 After reset release, no frame SHALL start without a new valid pulse.

Structure
REQ-026 State enum, DATA_WIDTH and DIV_WIDTH defaults SHALL live in the shared uart package used by the UART blocks.
REQ-027 Parity computation SHALL be a sub-module, uart_parity_calc (data, par_typ -> parity bit).
REQ-028 Single clock domain; no latches; one FSM.

Verification
REQ-029 data=0xA5, par_en=0, div=4, valid pulse -> line 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles; busy high for 40 cycles.
REQ-030 data=0x07, par_en=1, par_typ=0, div=2 -> parity bit 1; frame 22 cycles. With par_typ=1 -> parity bit 0.
REQ-031 Valid pulse mid-frame with data=0xFF during a 0x00 frame -> ignored; frame completes unchanged; no second frame.
REQ-032 Reset asserted during DATA bit 3 -> o_tx_out=1 and busy=0 immediately; idle after release until next valid.
REQ-033 div=0, data=0x55, no parity -> 1 cycle per bit; 10-cycle frame.
REQ-034 Valid pulse on the first IDLE cycle after a frame -> second frame accepted; line high exactly 1 cycle between frames.
